// File: rtl/lsu_axil_master.sv
// Load/store unit master: turns one M-stage memory request at a time into an
// AXI4-Lite read or write, formats store lanes and extends load data.
module lsu_axil_master #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  // response side
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  // AXI4-Lite read address
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  // AXI4-Lite read data
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  // AXI4-Lite write address
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  // AXI4-Lite write data
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  // AXI4-Lite write response
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WRITE,
    S_WRESP,
    S_ERR
  } state_e;

  state_e              state_q,      state_d;
  logic                req_ready_q,  req_ready_d;
  logic [ADDR_W-1:0]   axi_addr_q,   axi_addr_d;
  logic [1:0]          lane_q,       lane_d;
  logic [1:0]          size_q,       size_d;
  logic                uns_q,        uns_d;
  logic                arvalid_q,    arvalid_d;
  logic                rready_q,     rready_d;
  logic                awvalid_q,    awvalid_d;
  logic                wvalid_q,     wvalid_d;
  logic                bready_q,     bready_d;
  logic [DATA_W-1:0]   wdata_q,      wdata_d;
  logic [STRB_W-1:0]   wstrb_q,      wstrb_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q,   resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  // Half needs addr[0]==0, word (and size 11) needs addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if (size == 2'b01)      mis = lane[0];
    else if (size != 2'b00) mis = (lane != 2'b00);
    return mis;
  endfunction

  // Select the addressed byte/half of the read word and extend it.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] d,
                                                     input logic [1:0] lane,
                                                     input logic [1:0] size,
                                                     input logic uns);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = d[{lane, 3'b000} +: 8];
    h = d[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Next-state and next-output computation.
  always_comb begin
    state_d      = state_q;
    axi_addr_d   = axi_addr_q;
    lane_d       = lane_q;
    size_d       = size_q;
    uns_d        = uns_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          axi_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          lane_d     = req_addr[1:0];
          size_d     = req_size;
          uns_d      = req_unsigned;
          case (req_size)
            2'b00: begin
              wdata_d = {4{req_wdata[7:0]}};
              wstrb_d = STRB_W'(4'b0001 << req_addr[1:0]);
            end
            2'b01: begin
              wdata_d = {2{req_wdata[15:0]}};
              wstrb_d = STRB_W'(4'b0011 << req_addr[1:0]);
            end
            default: begin
              wdata_d = req_wdata;
              wstrb_d = 4'b1111;
            end
          endcase
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d = S_ERR;
          end else if (req_we) begin
            state_d   = S_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_RADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (rvalid) begin
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (rresp != 2'b00);
          resp_rdata_d = load_extract(rdata, lane_q, size_q, uns_q);
          state_d      = S_IDLE;
        end
      end
      S_WRITE: begin
        // AW and W retire independently; move on once both are gone.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (bvalid) begin
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (bresp != 2'b00);
          state_d      = S_IDLE;
        end
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready_d = (state_d == S_IDLE);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      axi_addr_q   <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      axi_addr_q   <= axi_addr_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign araddr     = axi_addr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign awaddr     = axi_addr_q;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;

endmodule
